fft_out_serializer: RTL
=======================

Name: fft_out_serializer

Overview:
- Sits directly downstream of the 32-point FFT core.
- Captures one parallel frame of 32 complex 19-bit results when the core asserts valid.
- Streams the results out one sample per cycle over a valid/ready interface.
- Double-buffered, so the core can deliver the next frame while the current frame drains.

Parameters:
- N, 32, points per frame (power of two; this block is verified at 32 only).
- DW, 19, width of each real and each imaginary component.
- BIT_REVERSE, 0, when 1, read order is the bit-reversed index, so a bit-reversed core output leaves in natural order.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_p_i  in  1  synchronous reset, active-high.
- frame_valid_i  in  1  one-cycle pulse from the FFT core: the frame is present on frame_r_i/frame_i_i.
- frame_r_i  in  N*DW  real parts, flattened; element k occupies bits [k*DW +: DW].
- frame_i_i  in  N*DW  imaginary parts, same packing as frame_r_i.
- frame_ready_o  out  1  high when a bank is free to accept a frame.
- sample_valid_o  out  1  output sample valid.
- sample_ready_i  in  1  downstream accepts the sample.
- sample_r_o  out  DW  real part of the current sample.
- sample_i_o  out  DW  imaginary part of the current sample.
- sample_idx_o  out  log2(N)  output position of the sample, 0..N-1.
- sample_last_o  out  1  high with the final sample of a frame (idx N-1).
- overflow_o  out  1  sticky: a frame arrived while no bank was free.

Behaviour:
- Storage: two banks (0/1), each N x 2 x DW, each with a full flag.
- Registers: wbank (write-bank pointer), rbank (read-bank pointer), rd_idx (log2(N) bits), overflow.
- Reset (sync, reset_p_i high at a rising edge):
  - full flags, wbank, rbank, rd_idx and overflow all cleared to 0.
  - Bank contents are not cleared.
  - Resulting outputs: frame_ready_o=1, sample_valid_o=0, sample_last_o=0, overflow_o=0, sample_idx_o=0, sample_r_o/sample_i_o=0.
  - Reset overrides capture and transfer in the same cycle; any frame in flight is discarded.
- frame_ready_o = !full[wbank] (combinational from registers).
- Capture:
  - When frame_valid_i && frame_ready_o at an edge: frame copied into bank[wbank], full[wbank] set, wbank toggles.
  - When frame_valid_i && !frame_ready_o: frame dropped, overflow set; it stays set until reset.
- Output side:
  - sample_valid_o = full[rbank].
  - First sample is valid on the cycle after the capture edge (latency 1).
  - Read address = BIT_REVERSE ? bitrev(rd_idx) : rd_idx.
  - sample_r_o/sample_i_o = bank[rbank][addr] when valid, else 0.
  - sample_idx_o = rd_idx; sample_last_o = sample_valid_o && (rd_idx == N-1).
- Transfer (sample_valid_o && sample_ready_i):
  - rd_idx increments.
  - On the last sample: rd_idx wraps to 0, full[rbank] clears, rbank toggles.
- Stall: while sample_valid_o && !sample_ready_i, all sample outputs hold stable.
- Zero-bubble stream: with sample_ready_i held high and both banks full, frames stream back-to-back with no idle cycle between the last sample of one frame and the first of the next.
- Simultaneous events:
  - Capture into the free bank and transfer from the other bank in the same cycle are independent; both take effect.
  - The bank freed by a last-sample transfer is not accepted in that same cycle, because frame_ready_o uses registered flags; it is accepted from the next cycle.
- Throughput: one frame per N cycles sustained; the core may deliver at most one frame per N cycles without overflow.

Decomposition:
- Shared fft_pkg holds:
  - FFT_N=32, FFT_LOG2N=5, FFT_IN_W=14, FFT_OUT_W=19.
  - A bitrev function.
  - A complex-sample struct {re, im} of FFT_OUT_W each.
- One natural sub-module: fft_frame_bank, a single bank with parallel write, indexed read and full flag, instantiated twice.

Test Plan:
- Reset then an idle frame_valid_i pulse carrying frame_r_i element k = k, frame_i_i element k = -k; sample_ready_i held 1 -> from the next cycle, 32 consecutive samples with sample_r_o=0..31 and sample_i_o=0..-31 (19-bit two's complement); sample_last_o high only at idx 31; overflow_o=0.
- BIT_REVERSE=1, same frame -> sample at idx 1 has sample_r_o=16, idx 2 has 8, idx 31 has 31.
- Two frames 1 cycle apart, sample_ready_i=1 -> 64 samples contiguous with no gap; frame_ready_o=0 after the second capture until the first frame's last transfer +1 cycle.
- Three frames on consecutive cycles with sample_ready_i=0 -> third frame dropped, overflow_o=1 and stays 1; then set sample_ready_i=1 -> only frames 1 and 2 emerge.
- Toggle sample_ready_i 1/0 every cycle -> outputs stable during stalls, frame fully drained in 64 cycles, order intact.
- Assert reset_p_i at sample idx 10 of a frame -> next cycle sample_valid_o=0, frame_ready_o=1, overflow_o=0; a new frame afterwards starts at idx 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Constants, sample type and index helpers shared by the FFT datapath.
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_IN_W  = 14;
  localparam int FFT_OUT_W = 19;

  typedef struct packed {
    logic signed [FFT_OUT_W-1:0] re;
    logic signed [FFT_OUT_W-1:0] im;
  } cplx_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [FFT_LOG2N-1:0] bitrev(
    input logic [FFT_LOG2N-1:0] v,
    input int                   w
  );
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      if (b < w) begin
        r[b] = v[FFT_LOG2N'(w - 1 - b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer: parallel capture of a whole frame, indexed read, full flag.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int DW = FFT_OUT_W,
  localparam int LW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [N*DW-1:0] wr_r,
  input  logic [N*DW-1:0] wr_i,
  input  logic            clr,
  input  logic [LW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_r,
  output logic [DW-1:0]   rd_i,
  output logic            full
);

  logic [DW-1:0] mem_r [N];
  logic [DW-1:0] mem_i [N];

  // Contents are left alone by reset; only the flag says what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        mem_r[k] <= wr_r[k*DW +: DW];
        mem_i[k] <= wr_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

  assign rd_r = mem_r[rd_addr];
  assign rd_i = mem_i[rd_addr];

endmodule

// File: rtl/fft_out_serializer.sv
// Double-buffered capture of FFT frames, streamed out one sample per cycle.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int DW          = FFT_OUT_W,
  parameter bit BIT_REVERSE = 1'b0,
  localparam int LW = $clog2(N)
) (
  input  logic            clk_p_i,
  input  logic            reset_p_i,
  input  logic            frame_valid_i,
  input  logic [N*DW-1:0] frame_r_i,
  input  logic [N*DW-1:0] frame_i_i,
  output logic            frame_ready_o,
  output logic            sample_valid_o,
  input  logic            sample_ready_i,
  output logic [DW-1:0]   sample_r_o,
  output logic [DW-1:0]   sample_i_o,
  output logic [LW-1:0]   sample_idx_o,
  output logic            sample_last_o,
  output logic            overflow_o
);

  logic [1:0]    full;
  logic [1:0]    wr_en;
  logic [1:0]    clr;
  logic [DW-1:0] rd_r [2];
  logic [DW-1:0] rd_i [2];
  logic          wbank;
  logic          rbank;
  logic          overflow;
  logic [LW-1:0] rd_idx;
  logic [LW-1:0] rd_addr;
  logic          cap;
  logic          xfer;
  logic          at_end;

  assign frame_ready_o  = !full[wbank];
  assign sample_valid_o = full[rbank];

  assign cap    = frame_valid_i && frame_ready_o && !reset_p_i;
  assign xfer   = sample_valid_o && sample_ready_i;
  assign at_end = rd_idx == LW'(N - 1);

  assign wr_en = {cap && wbank, cap && !wbank};
  assign clr   = {xfer && at_end && rbank, xfer && at_end && !rbank};

  assign rd_addr = BIT_REVERSE
                 ? LW'(bitrev(FFT_LOG2N'(rd_idx), LW))
                 : rd_idx;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .N  (N),
      .DW (DW)
    ) u_bank (
      .clk     (clk_p_i),
      .rst     (reset_p_i),
      .wr_en   (wr_en[b]),
      .wr_r    (frame_r_i),
      .wr_i    (frame_i_i),
      .clr     (clr[b]),
      .rd_addr (rd_addr),
      .rd_r    (rd_r[b]),
      .rd_i    (rd_i[b]),
      .full    (full[b])
    );
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      rd_idx   <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap) begin
        wbank <= ~wbank;
      end
      if (frame_valid_i && !frame_ready_o) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        rd_idx <= at_end ? '0 : rd_idx + LW'(1);
        if (at_end) begin
          rbank <= ~rbank;
        end
      end
    end
  end

  assign sample_r_o    = sample_valid_o ? rd_r[rbank] : '0;
  assign sample_i_o    = sample_valid_o ? rd_i[rbank] : '0;
  assign sample_idx_o  = rd_idx;
  assign sample_last_o = sample_valid_o && at_end;
  assign overflow_o    = overflow;

endmodule
